// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package sync_fifo_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

   // Encoding equals the number of buffered words.
   function automatic logic [1:0] occ_words(input occ_state_e s);
      return s;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] inc,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, inc};
      if (sum > {1'b0, max_val}) begin
         return max_val;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/skid_buf_2e.sv
// Two-entry skid buffer: head is the presented word, skid catches one extra word while the sink stalls.
// A write lands in head when empty (or when head drains the same cycle), otherwise in skid.
module skid_buf_2e
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  take,
   input  logic                  clear,
   output occ_state_e            occ,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] skid;
   occ_state_e            occ_nxt;
   logic                  load_head;
   logic                  load_skid;
   logic                  shift;

   always_comb begin
      occ_nxt   = occ;
      load_head = 1'b0;
      load_skid = 1'b0;
      shift     = 1'b0;
      if (clear) begin
         occ_nxt = OCC_EMPTY;
      end else begin
         case (occ)
            OCC_EMPTY: begin
               if (in_valid) begin
                  occ_nxt   = OCC_ONE;
                  load_head = 1'b1;
               end
            end
            OCC_ONE: begin
               if (in_valid && !take) begin
                  occ_nxt   = OCC_TWO;
                  load_skid = 1'b1;
               end else if (in_valid && take) begin
                  load_head = 1'b1;
               end else if (take) begin
                  occ_nxt = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (take) begin
                  occ_nxt = OCC_ONE;
                  shift   = 1'b1;
               end
            end
            default: occ_nxt = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         occ  <= OCC_EMPTY;
         head <= '0;
         skid <= '0;
      end else begin
         occ <= occ_nxt;
         if (load_head) begin
            head <= in_data;
         end else if (shift) begin
            head <= skid;
         end
         if (load_skid) begin
            skid <= in_data;
         end
      end
   end

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Drains a show-ahead FIFO into a registered valid/ready stream, 1 cycle pop-to-valid, 1 word/cycle.
// Pop depends only on buffer occupancy, so m_ready never reaches fifo_pop combinationally.
module sync_fifo_rd_stream
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  fifo_valid,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_pop,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  flush,
   output logic [CNT_WIDTH-1:0]  xfer_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam logic [31:0] CNT_MAX = 32'({CNT_WIDTH{1'b1}});

   occ_state_e  occ;
   logic        take;
   logic [31:0] drop_sum;

   assign m_valid  = (occ != OCC_EMPTY) & ~flush & rstn;
   assign take     = m_valid & m_ready;
   // During flush the FIFO is drained regardless of buffer occupancy.
   assign fifo_pop = rstn & fifo_valid & (flush | (occ != OCC_TWO));

   skid_buf_2e #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (fifo_pop & ~flush),
      .in_data  (fifo_rd_data),
      .take     (take),
      .clear    (flush),
      .occ      (occ),
      .head     (m_data)
   );

   assign drop_sum = sat_add(32'(drop_cnt), 32'(occ_words(occ)) + 32'(fifo_pop), CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         xfer_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (take) begin
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
         end
         if (flush) begin
            drop_cnt <= drop_sum[CNT_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Directed bench for sync_fifo_rd_stream with a behavioural show-ahead FIFO in front of it.
module tb_sync_fifo_rd_stream;

   logic        clk;
   logic        rstn;
   logic        fifo_valid;
   logic [31:0] fifo_rd_data;
   logic        fifo_pop;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        flush;
   logic [3:0]  xfer_cnt;
   logic [3:0]  drop_cnt;

   int total;
   int bad;

   // Behavioural FIFO; fifo_en gates its valid so words can be preloaded unseen.
   logic [31:0] q[$];
   logic        fv_q;
   logic [31:0] fd_q;
   logic        fifo_en;
   logic        fifo_clr;
   logic        push_en;
   logic [31:0] push_data;
   int          pop_empty;

   assign fifo_valid   = fv_q & fifo_en;
   assign fifo_rd_data = fd_q;

   sync_fifo_rd_stream #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (4)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .fifo_valid   (fifo_valid),
      .fifo_rd_data (fifo_rd_data),
      .fifo_pop     (fifo_pop),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .flush        (flush),
      .xfer_cnt     (xfer_cnt),
      .drop_cnt     (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (fifo_clr) begin
         q.delete();
      end else begin
         if (fifo_pop) begin
            if (q.size() == 0) pop_empty <= pop_empty + 1;
            else void'(q.pop_front());
         end
         if (push_en) q.push_back(push_data);
      end
      fv_q <= (q.size() != 0);
      fd_q <= (q.size() != 0) ? q[0] : 32'h0;
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic push_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         push_data = base + 32'(i);
         push_en   = 1'b1;
         tick();
      end
      push_en = 1'b0;
   endtask

   task automatic do_reset;
      rstn     = 1'b0;
      flush    = 1'b0;
      m_ready  = 1'b0;
      push_en  = 1'b0;
      fifo_en  = 1'b0;
      fifo_clr = 1'b1;
      tick();
      tick();
      fifo_clr = 1'b0;
      rstn     = 1'b1;
   endtask

   task automatic test_reset;
      rstn = 1'b0; flush = 1'b0; m_ready = 1'b1; fifo_en = 1'b0; fifo_clr = 1'b0; push_en = 1'b0;
      push_words(32'hA0, 2);
      fifo_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (fifo_pop !== 1'b0) begin bad++; $display("FAIL reset_pop c%0d: got %b want 0", c, fifo_pop); end
         total++;
         if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_mvalid c%0d: got %b want 0", c, m_valid); end
         tick();
      end
      total++;
      if (xfer_cnt !== 4'd0) begin bad++; $display("FAIL reset_xfer: got %0d want 0", xfer_cnt); end
      total++;
      if (drop_cnt !== 4'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      total++;
      if (m_data !== 32'h0) begin bad++; $display("FAIL reset_mdata: got %h want 0", m_data); end
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
      fifo_en  = 1'b0;
   endtask

   task automatic test_streaming;
      logic [31:0] exp_d;
      do_reset();
      push_words(32'h10, 8);
      m_ready = 1'b1;
      fifo_en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         total++;
         if (fifo_pop !== (c < 8)) begin bad++; $display("FAIL stream_pop c%0d: got %b want %b", c, fifo_pop, (c < 8)); end
         total++;
         if (m_valid !== (c >= 1 && c <= 8)) begin bad++; $display("FAIL stream_mvalid c%0d: got %b want %b", c, m_valid, (c >= 1 && c <= 8)); end
         if (c >= 1 && c <= 8) begin
            exp_d = 32'h10 + 32'(c) - 32'd1;
            total++;
            if (m_data !== exp_d) begin bad++; $display("FAIL stream_data c%0d: got %h want %h", c, m_data, exp_d); end
         end
         tick();
      end
      total++;
      if (xfer_cnt !== 4'd8) begin bad++; $display("FAIL stream_xfer: got %0d want 8", xfer_cnt); end
      total++;
      if (pop_empty !== 0) begin bad++; $display("FAIL stream_pop_empty: got %0d want 0", pop_empty); end
   endtask

   task automatic test_backpressure;
      bit          ep[10];
      bit          em[10];
      logic [31:0] ed[10];
      ep = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
      em = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      ed = '{32'h0, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h21, 32'h22, 32'h23, 32'h0};
      do_reset();
      push_words(32'h20, 4);
      fifo_en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         m_ready = (c >= 5);
         #1;
         total++;
         if (fifo_pop !== ep[c]) begin bad++; $display("FAIL bp_pop c%0d: got %b want %b", c, fifo_pop, ep[c]); end
         total++;
         if (m_valid !== em[c]) begin bad++; $display("FAIL bp_mvalid c%0d: got %b want %b", c, m_valid, em[c]); end
         if (em[c]) begin
            total++;
            if (m_data !== ed[c]) begin bad++; $display("FAIL bp_data c%0d: got %h want %h", c, m_data, ed[c]); end
         end
         tick();
      end
      total++;
      if (xfer_cnt !== 4'd4) begin bad++; $display("FAIL bp_xfer: got %0d want 4", xfer_cnt); end
   endtask

   task automatic test_flush;
      do_reset();
      push_words(32'h30, 5);
      fifo_en = 1'b1;
      tick();
      tick();
      #1;
      total++;
      if (m_valid !== 1'b1 || m_data !== 32'h30) begin bad++; $display("FAIL flush_pre: got v=%b d=%h want v=1 d=30", m_valid, m_data); end
      total++;
      if (fifo_pop !== 1'b0) begin bad++; $display("FAIL flush_pre_pop: got %b want 0", fifo_pop); end
      flush   = 1'b1;
      m_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         #1;
         total++;
         if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_mvalid f%0d: got %b want 0", f, m_valid); end
         total++;
         if (fifo_pop !== (f < 3)) begin bad++; $display("FAIL flush_pop f%0d: got %b want %b", f, fifo_pop, (f < 3)); end
         tick();
      end
      flush = 1'b0;
      #1;
      total++;
      if (drop_cnt !== 4'd5) begin bad++; $display("FAIL flush_drop: got %0d want 5", drop_cnt); end
      total++;
      if (m_valid !== 1'b0 || fifo_pop !== 1'b0) begin bad++; $display("FAIL flush_idle: got v=%b pop=%b want 0 0", m_valid, fifo_pop); end
      total++;
      if (xfer_cnt !== 4'd0) begin bad++; $display("FAIL flush_xfer: got %0d want 0", xfer_cnt); end
      push_data = 32'h40;
      push_en   = 1'b1;
      tick();
      push_en = 1'b0;
      #1;
      total++;
      if (fifo_pop !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL flush_resume_pop: got pop=%b v=%b want 1 0", fifo_pop, m_valid); end
      tick();
      #1;
      total++;
      if (m_valid !== 1'b1 || m_data !== 32'h40) begin bad++; $display("FAIL flush_resume_data: got v=%b d=%h want v=1 d=40", m_valid, m_data); end
      tick();
   endtask

   task automatic test_sat_wrap;
      do_reset();
      m_ready = 1'b1;
      fifo_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_data = 32'h60 + 32'(i);
         push_en   = 1'b1;
         tick();
      end
      push_en = 1'b0;
      repeat (4) tick();
      #1;
      total++;
      if (xfer_cnt !== 4'd4) begin bad++; $display("FAIL wrap_xfer: got %0d want 4", xfer_cnt); end
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL wrap_idle: got %b want 0", m_valid); end
      flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_data = 32'h80 + 32'(i);
         push_en   = 1'b1;
         tick();
      end
      push_en = 1'b0;
      repeat (3) tick();
      flush = 1'b0;
      #1;
      total++;
      if (drop_cnt !== 4'd15) begin bad++; $display("FAIL sat_drop: got %0d want 15", drop_cnt); end
      total++;
      if (xfer_cnt !== 4'd4) begin bad++; $display("FAIL sat_xfer_hold: got %0d want 4", xfer_cnt); end
      tick();
   endtask

   task automatic test_reset_mid;
      logic [31:0] got[$];
      do_reset();
      push_words(32'h50, 4);
      fifo_en = 1'b1;
      tick();
      tick();
      #1;
      total++;
      if (m_valid !== 1'b1 || m_data !== 32'h50 || fifo_pop !== 1'b0) begin
         bad++; $display("FAIL rmid_two: got v=%b d=%h pop=%b want 1 50 0", m_valid, m_data, fifo_pop);
      end
      rstn = 1'b0;
      #1;
      total++;
      if (m_valid !== 1'b0 || fifo_pop !== 1'b0) begin bad++; $display("FAIL rmid_in_reset: got v=%b pop=%b want 0 0", m_valid, fifo_pop); end
      tick();
      #1;
      total++;
      if (m_data !== 32'h0) begin bad++; $display("FAIL rmid_head_clr: got %h want 0", m_data); end
      rstn    = 1'b1;
      m_ready = 1'b1;
      #1;
      total++;
      if (m_valid !== 1'b0 || fifo_pop !== 1'b1) begin bad++; $display("FAIL rmid_release: got v=%b pop=%b want 0 1", m_valid, fifo_pop); end
      for (int c = 0; c < 6; c++) begin
         if (m_valid && m_ready) got.push_back(m_data);
         tick();
         #1;
      end
      total++;
      if (got.size() != 2) begin
         bad++; $display("FAIL rmid_count: got %0d want 2", got.size());
      end else begin
         total++;
         if (got[0] !== 32'h52 || got[1] !== 32'h53) begin bad++; $display("FAIL rmid_order: got %h %h want 52 53", got[0], got[1]); end
      end
      total++;
      if (xfer_cnt !== 4'd2) begin bad++; $display("FAIL rmid_xfer: got %0d want 2", xfer_cnt); end
      total++;
      if (pop_empty !== 0) begin bad++; $display("FAIL rmid_pop_empty: got %0d want 0", pop_empty); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total     = 0;
      bad       = 0;
      pop_empty = 0;
      push_data = 32'h0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_sat_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
